os_result_drain: RTL and testbench

- Read-out controller at the output edge of the output-stationary systolic array.
- On a tile-done handshake from the compute sequencer, it pulses load_en to every PE so accumulators are copied into their shadow result registers.
- It then walks a row select across the array's shadow-result mux and streams one row of COLS results per beat downstream on a valid/ready interface.
- The array can start the next tile's accumulation while the previous tile drains.

---
 rtl/os_array_pkg.sv | 30 +++
 rtl/os_drain_out_reg.sv | 84 ++++++++
 rtl/os_result_drain.sv | 102 ++++++++++
 tb/tb_os_result_drain.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/os_array_pkg.sv
// Shared types and constants for the output-stationary array read-out path.
// Holds the drain FSM encoding, default geometry and the saturation test.
package os_array_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } drain_state_e;

    localparam int DEF_ROWS      = 4;
    localparam int DEF_COLS      = 4;
    localparam int DEF_ACC_WIDTH = 24;
    localparam int MAX_ACC_WIDTH = 64;

    // Lane values are zero-extended into a fixed container; only the low
    // 'width' bits take part, so one function serves any ACC_WIDTH <= 64.
    function automatic logic is_saturated(input logic [MAX_ACC_WIDTH-1:0] value,
                                          input int width);
        logic sat;
        sat = 1'b1;
        for (int i = 0; i < MAX_ACC_WIDTH; i++) begin
            if ((i < width) && !value[i]) begin
                sat = 1'b0;
            end
        end
        return sat;
    endfunction

endpackage

// File: rtl/os_drain_out_reg.sv
// Output register / valid-hold stage for the result drain: captures one row per beat.
// Latency: 1 cycle from capture to out_valid; holds the beat while out_ready is low.
module os_drain_out_reg
    import os_array_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int RSEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cap_req,
    input  logic [COLS*ACC_WIDTH-1:0] row_data,
    input  logic [RSEL_W-1:0]         row_idx,
    input  logic                      row_last,
    input  logic                      out_ready,
    output logic                      capture,
    output logic                      out_valid,
    output logic [COLS*ACC_WIDTH-1:0] out_data,
    output logic [RSEL_W-1:0]         out_row,
    output logic                      out_last,
    output logic                      out_sat
);

    logic                      out_valid_d, out_valid_q;
    logic [COLS*ACC_WIDTH-1:0] out_data_d,  out_data_q;
    logic [RSEL_W-1:0]         out_row_d,   out_row_q;
    logic                      out_last_d,  out_last_q;
    logic                      out_sat_d,   out_sat_q;
    logic                      row_sat;
    logic [MAX_ACC_WIDTH-1:0]  lane_ext;

    always_comb begin
        row_sat  = 1'b0;
        lane_ext = '0;
        for (int c = 0; c < COLS; c++) begin
            lane_ext                = '0;
            lane_ext[ACC_WIDTH-1:0] = row_data[c*ACC_WIDTH +: ACC_WIDTH];
            row_sat                 = row_sat | is_saturated(lane_ext, ACC_WIDTH);
        end
    end

    // The register is free when empty or when its beat leaves this cycle.
    always_comb begin
        capture     = cap_req && (!out_valid_q || out_ready);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_last_d  = out_last_q;
        out_sat_d   = out_sat_q;
        if (capture) begin
            out_valid_d = 1'b1;
            out_data_d  = row_data;
            out_row_d   = row_idx;
            out_last_d  = row_last;
            out_sat_d   = row_sat;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_last_q  <= out_last_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_last  = out_last_q;
    assign out_sat   = out_sat_q;

endmodule

// File: rtl/os_result_drain.sv
// Drains shadow results of the systolic array one row per beat after a tile-done handshake.
// Latency: load_en at T+1, first beat valid at T+3; out_ready low stalls row walk and output.
module os_result_drain
    import os_array_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int RSEL_W    = $clog2(ROWS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tile_done_valid,
    output logic                      tile_done_ready,
    output logic                      load_en,
    output logic [RSEL_W-1:0]         row_sel,
    input  logic [COLS*ACC_WIDTH-1:0] row_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*ACC_WIDTH-1:0] out_data,
    output logic [RSEL_W-1:0]         out_row,
    output logic                      out_last,
    output logic                      out_sat,
    output logic                      drain_busy
);

    drain_state_e      state_d, state_q;
    logic [RSEL_W-1:0] row_cnt_d, row_cnt_q;
    logic              cap_req;
    logic              capture;
    logic              row_last;

    assign cap_req  = (state_q == STREAM);
    assign row_last = (row_cnt_q == RSEL_W'(ROWS-1));

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (tile_done_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d   = STREAM;
                row_cnt_d = '0;
            end
            STREAM: begin
                // Row walk advances only when the output stage takes the row.
                if (capture) begin
                    if (row_last) begin
                        state_d   = IDLE;
                        row_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + RSEL_W'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                row_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    os_drain_out_reg #(
        .COLS      (COLS),
        .ACC_WIDTH (ACC_WIDTH),
        .RSEL_W    (RSEL_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_req   (cap_req),
        .row_data  (row_data),
        .row_idx   (row_cnt_q),
        .row_last  (row_last),
        .out_ready (out_ready),
        .capture   (capture),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .out_sat   (out_sat)
    );

    assign tile_done_ready = (state_q == IDLE);
    assign load_en         = (state_q == LOAD);
    assign row_sel         = row_cnt_q;
    assign drain_busy      = (state_q != IDLE) || out_valid;

endmodule

// File: tb/tb_os_result_drain.sv
// Directed bench for os_result_drain: cycle table for a plain tile, then
// hand-written backpressure, saturation, back-to-back, reset and ignored-request sequences.
module tb_os_result_drain;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int AW   = 24;
    localparam int RW   = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               tile_done_valid;
    logic               tile_done_ready;
    logic               load_en;
    logic [RW-1:0]      row_sel;
    logic [COLS*AW-1:0] row_data;
    logic               out_valid;
    logic               out_ready;
    logic [COLS*AW-1:0] out_data;
    logic [RW-1:0]      out_row;
    logic               out_last;
    logic               out_sat;
    logic               drain_busy;

    logic [AW-1:0] arr [ROWS][COLS];
    int checks = 0;
    int errors = 0;
    int rows_q[$];

    always #5 clk = ~clk;

    os_result_drain dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tile_done_valid (tile_done_valid),
        .tile_done_ready (tile_done_ready),
        .load_en         (load_en),
        .row_sel         (row_sel),
        .row_data        (row_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_row         (out_row),
        .out_last        (out_last),
        .out_sat         (out_sat),
        .drain_busy      (drain_busy)
    );

    // Array model: shadow result mux, combinational from row_sel.
    always_comb begin
        row_data = '0;
        for (int c = 0; c < COLS; c++) begin
            row_data[c*AW +: AW] = arr[row_sel][c];
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            rows_q.push_back(int'(out_row));
        end
    end

    function automatic logic [COLS*AW-1:0] row_word(input int r);
        logic [COLS*AW-1:0] w;
        w = '0;
        for (int c = 0; c < COLS; c++) begin
            w[c*AW +: AW] = arr[r][c];
        end
        return w;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile();
        tile_done_valid = 1'b1;
        step();
        tile_done_valid = 1'b0;
    endtask

    task automatic chk_rows(input string nm, input int exp_rows[$]);
        chk({nm, "_count"}, 128'(rows_q.size()), 128'(exp_rows.size()));
        for (int i = 0; i < exp_rows.size() && i < rows_q.size(); i++) begin
            chk({nm, "_order"}, 128'(rows_q[i]), 128'(exp_rows[i]));
        end
    endtask

    typedef struct {
        logic         tv;
        logic         rdy;
        logic         e_tdr;
        logic         e_load;
        logic         e_ov;
        logic [RW-1:0] e_row;
        logic         e_last;
        logic [RW-1:0] e_sel;
        logic         e_busy;
    } vec_t;

    vec_t vt [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        int hs_cnt;
        int hs_k [2];

        // cycle 0 is the handshake cycle T
        vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1};
        vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1};
        vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1, 1'b1};
        vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd2, 1'b1};
        vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd3, 1'b1};
        vt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 2'd0, 1'b1};
        vt[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                arr[r][c] = AW'(16*r + c);

        rst_n = 1'b0;
        tile_done_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_out_row", 128'(out_row), 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        chk("rst_out_sat", 128'(out_sat), 128'(0));
        chk("rst_load_en", 128'(load_en), 128'(0));
        chk("rst_row_sel", 128'(row_sel), 128'(0));
        step();
        rst_n = 1'b1;
        step();

        // Single tile, table driven
        rows_q.delete();
        for (int k = 0; k < 8; k++) begin
            tile_done_valid = vt[k].tv;
            out_ready       = vt[k].rdy;
            @(negedge clk);
            chk($sformatf("t1_c%0d_tdr", k), 128'(tile_done_ready), 128'(vt[k].e_tdr));
            chk($sformatf("t1_c%0d_load", k), 128'(load_en), 128'(vt[k].e_load));
            chk($sformatf("t1_c%0d_valid", k), 128'(out_valid), 128'(vt[k].e_ov));
            chk($sformatf("t1_c%0d_sel", k), 128'(row_sel), 128'(vt[k].e_sel));
            chk($sformatf("t1_c%0d_busy", k), 128'(drain_busy), 128'(vt[k].e_busy));
            if (vt[k].e_ov) begin
                chk($sformatf("t1_c%0d_row", k), 128'(out_row), 128'(vt[k].e_row));
                chk($sformatf("t1_c%0d_last", k), 128'(out_last), 128'(vt[k].e_last));
                chk($sformatf("t1_c%0d_sat", k), 128'(out_sat), 128'(0));
                chk($sformatf("t1_c%0d_data", k), 128'(out_data), 128'(row_word(int'(vt[k].e_row))));
            end
            step();
        end
        chk_rows("t1_rows", '{0, 1, 2, 3});

        // Backpressure on row 1
        rows_q.delete();
        start_tile();               // now T+1
        step(); step(); step();     // T+4: row 1 presented
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_row", 128'(out_row), 128'(1));
            chk("bp_data", 128'(out_data), 128'(row_word(1)));
            chk("bp_sel", 128'(row_sel), 128'(2));
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk_rows("bp_rows", '{0, 1, 2, 3});

        // Saturation in row 2 lane 3
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                arr[r][c] = '0;
        arr[2][3] = 24'hFFFFFF;
        start_tile();
        step();                     // T+2
        for (int r = 0; r < ROWS; r++) begin
            step();
            @(negedge clk);
            chk($sformatf("sat_r%0d_valid", r), 128'(out_valid), 128'(1));
            chk($sformatf("sat_r%0d_flag", r), 128'(out_sat), 128'(r == 2));
            chk($sformatf("sat_r%0d_data", r), 128'(out_data),
                (r == 2) ? {32'h0, 24'hFFFFFF, 72'h0} : 128'(0));
        end
        step(); step();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                arr[r][c] = AW'(16*r + c);

        // Back-to-back tiles with tile_done_valid held
        rows_q.delete();
        lc = 0;
        hs_cnt = 0;
        hs_k[0] = -1;
        hs_k[1] = -1;
        tile_done_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (load_en) lc++;
            if (tile_done_valid && tile_done_ready) begin
                if (hs_cnt < 2) hs_k[hs_cnt] = k;
                hs_cnt++;
            end
            step();
            if (hs_cnt >= 2) tile_done_valid = 1'b0;
        end
        chk("b2b_hs_count", 128'(hs_cnt), 128'(2));
        chk("b2b_hs1_cycle", 128'(hs_k[0]), 128'(0));
        chk("b2b_hs2_cycle", 128'(hs_k[1]), 128'(6));
        chk("b2b_load_pulses", 128'(lc), 128'(2));
        chk_rows("b2b_rows", '{0, 1, 2, 3, 0, 1, 2, 3});

        // Reset mid-drain after row 1 is emitted
        rows_q.delete();
        start_tile();
        step(); step(); step();     // T+4
        step();                     // T+5: row 2 presented
        rst_n = 1'b0;
        #2;
        chk("mrst_valid", 128'(out_valid), 128'(0));
        chk("mrst_data", 128'(out_data), 128'(0));
        chk("mrst_row", 128'(out_row), 128'(0));
        chk("mrst_last", 128'(out_last), 128'(0));
        chk("mrst_sel", 128'(row_sel), 128'(0));
        chk("mrst_busy", 128'(drain_busy), 128'(0));
        chk_rows("mrst_pre_rows", '{0, 1});
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mrst_post_valid", 128'(out_valid), 128'(0));
            chk("mrst_post_tdr", 128'(tile_done_ready), 128'(1));
            step();
        end
        rows_q.delete();
        start_tile();
        step();
        step();                     // T+3
        @(negedge clk);
        chk("mrst_fresh_row", 128'(out_row), 128'(0));
        chk("mrst_fresh_data", 128'(out_data), 128'(row_word(0)));
        for (int k = 0; k < 5; k++) step();
        chk_rows("mrst_fresh_rows", '{0, 1, 2, 3});

        // Request pulsed during STREAM is ignored
        rows_q.delete();
        lc = 0;
        start_tile();               // T+1
        for (int k = 1; k < 11; k++) begin
            tile_done_valid = (k == 3 || k == 4);
            @(negedge clk);
            if (load_en) lc++;
            if (k >= 2 && k <= 5)
                chk($sformatf("ign_c%0d_tdr", k), 128'(tile_done_ready), 128'(0));
            step();
        end
        chk("ign_load_pulses", 128'(lc), 128'(1));
        chk_rows("ign_rows", '{0, 1, 2, 3});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
